// File: rtl/cg_mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM states,
// port indices and the width of the read-wait counter.
package cg_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE
  } arb_state_t;

  localparam bit PORT_IF = 1'b0;
  localparam bit PORT_LS = 1'b1;

  // Wide enough for the largest supported TIMEOUT (255).
  localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/cg_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, contention goes
// to the port that did not win the previous acceptance.
module cg_rr_arbiter2
  import cg_mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = req;
    if (&req) begin
      grant[PORT_IF] = (last_grant == PORT_LS);
      grant[PORT_LS] = (last_grant == PORT_IF);
    end
  end

  // Reset value makes the fetch port win the first contention.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_grant <= PORT_LS;
    end else if (update) begin
      last_grant <= grant[PORT_LS];
    end
  end

endmodule

// File: rtl/cg_mem_arbiter.sv
// Arbitrates a read-only fetch port and a load/store port onto a single
// memory interface with one outstanding transaction and a read timeout.
module cg_mem_arbiter
  import cg_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_if_valid,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ready,
  output logic                  o_if_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_err,
  input  logic                  i_if_cancel,
  input  logic                  i_ls_valid,
  input  logic                  i_ls_we,
  input  logic [ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [DATA_WIDTH-1:0] i_ls_wdata,
  output logic                  o_ls_ready,
  output logic                  o_ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_ls_rdata,
  output logic                  o_ls_err,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic                  i_mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_mem_wen,
  output logic                  o_mem_wdata_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic owner_q;
  logic drop_q, drop_d;

  logic [1:0] req, grant;
  logic idle, accept, acc_port, acc_we, rd_busy, rd_done, drop_now;
  logic [ADDR_WIDTH-1:0] acc_addr;

  logic mem_ren_d, mem_wen_d;
  logic if_rsp_d, ls_rsp_d, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  assign req[PORT_IF] = i_if_valid;
  assign req[PORT_LS] = i_ls_valid;

  cg_rr_arbiter2 u_rr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .req    (req),
    .update (accept),
    .grant  (grant)
  );

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle & (|req);
  assign acc_port = grant[PORT_LS];
  assign acc_we   = acc_port & i_ls_we;
  assign acc_addr = acc_port ? i_ls_addr : i_if_addr;
  assign rd_busy  = (state_q == ST_RD_ISSUE) | (state_q == ST_RD_WAIT);
  // Data wins over a timeout that lands in the same cycle.
  assign rd_done  = (state_q == ST_RD_WAIT) & (i_mem_rdata_valid | (cnt_q == CNT_LAST));
  assign drop_now = drop_q | i_if_cancel;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = acc_we ? ST_WR_ISSUE : ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        if (rd_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_if_ready  = idle & grant[PORT_IF];
    o_ls_ready  = idle & grant[PORT_LS];
    mem_ren_d   = accept & ~acc_we;
    mem_wen_d   = accept & acc_we;
    if_rsp_d    = rd_done & (owner_q == PORT_IF) & ~drop_now;
    ls_rsp_d    = (rd_done & (owner_q == PORT_LS)) | (state_q == ST_WR_ISSUE);
    rsp_err_d   = rd_done & ~i_mem_rdata_valid;
    rsp_rdata_d = (rd_done & i_mem_rdata_valid) ? i_mem_rdata : '0;
    drop_d      = drop_q;
    if (idle) begin
      drop_d = 1'b0;
    end else if (rd_busy && (owner_q == PORT_IF) && i_if_cancel) begin
      drop_d = 1'b1;
    end
  end

  // Command outputs are only non-zero in the issue cycle; response data holds
  // between pulses so a consumer may sample it late.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q             <= '0;
      owner_q           <= PORT_IF;
      drop_q            <= 1'b0;
      o_mem_ren         <= 1'b0;
      o_mem_raddr       <= '0;
      o_mem_wen         <= 1'b0;
      o_mem_wdata_valid <= 1'b0;
      o_mem_waddr       <= '0;
      o_mem_wdata       <= '0;
      o_if_rsp_valid    <= 1'b0;
      o_if_rdata        <= '0;
      o_if_err          <= 1'b0;
      o_ls_rsp_valid    <= 1'b0;
      o_ls_rdata        <= '0;
      o_ls_err          <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      drop_q            <= drop_d;
      if (accept) begin
        owner_q <= acc_port;
      end
      o_mem_ren         <= mem_ren_d;
      o_mem_raddr       <= mem_ren_d ? acc_addr : '0;
      o_mem_wen         <= mem_wen_d;
      o_mem_wdata_valid <= mem_wen_d;
      o_mem_waddr       <= mem_wen_d ? acc_addr : '0;
      o_mem_wdata       <= mem_wen_d ? i_ls_wdata : '0;
      o_if_rsp_valid    <= if_rsp_d;
      if (if_rsp_d) begin
        o_if_rdata <= rsp_rdata_d;
        o_if_err   <= rsp_err_d;
      end
      o_ls_rsp_valid    <= ls_rsp_d;
      if (ls_rsp_d) begin
        o_ls_rdata <= rsp_rdata_d;
        o_ls_err   <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_cg_mem_arbiter.sv
// Self-checking bench for cg_mem_arbiter: directed scenarios plus randomized
// transactions compared against a cycle-offset model of the arbiter.
module tb_cg_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;
  localparam logic [AW-1:0] PEND_ADDR = 32'h0000_0ACE;
  localparam logic [DW-1:0] PEND_DATA = 32'hC0DE_0001;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b1;
  logic i_if_valid, i_if_cancel, i_ls_valid, i_ls_we, i_mem_rdata_valid;
  logic [AW-1:0] i_if_addr, i_ls_addr;
  logic [DW-1:0] i_ls_wdata, i_mem_rdata;
  logic o_if_ready, o_if_rsp_valid, o_if_err, o_ls_ready, o_ls_rsp_valid, o_ls_err;
  logic o_mem_ren, o_mem_wen, o_mem_wdata_valid;
  logic [DW-1:0] o_if_rdata, o_ls_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_raddr, o_mem_waddr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  cg_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
    .o_if_rsp_valid(o_if_rsp_valid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
    .i_if_cancel(i_if_cancel),
    .i_ls_valid(i_ls_valid), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_ready(o_ls_ready), .o_ls_rsp_valid(o_ls_rsp_valid),
    .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
    .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr),
    .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_rdata(i_mem_rdata),
    .o_mem_wen(o_mem_wen), .o_mem_wdata_valid(o_mem_wdata_valid),
    .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata)
  );

  logic [168:0] all_outs;
  assign all_outs = {o_if_ready, o_if_rsp_valid, o_if_rdata, o_if_err,
                     o_ls_ready, o_ls_rsp_valid, o_ls_rdata, o_ls_err,
                     o_mem_ren, o_mem_raddr, o_mem_wen, o_mem_wdata_valid,
                     o_mem_waddr, o_mem_wdata};

  // Observations of one transaction, cycles counted from the acceptance cycle (0).
  logic obs_ready, obs_other_ready;
  int ren_cnt, ren_cyc, wen_cnt, wen_cyc, wdv_cnt, ls_acc_cyc;
  int if_rsp_cnt, if_rsp_cyc, ls_rsp_cnt, ls_rsp_cyc;
  logic [AW-1:0] ren_addr, wen_addr;
  logic [DW-1:0] wen_data, if_rsp_data, ls_rsp_data;
  logic if_rsp_err, ls_rsp_err;

  // Reference model: a read answered lat cycles after ren completes one cycle
  // later, unless lat falls outside the TO-cycle wait window.
  function automatic bit model_timeout(input int lat);
    return !(lat >= 1 && lat <= TO);
  endfunction

  function automatic int model_rsp_cyc(input int lat);
    return model_timeout(lat) ? TO + 2 : lat + 2;
  endfunction

  task automatic idle_inputs();
    i_if_valid = 0; i_if_addr = '0; i_if_cancel = 0;
    i_ls_valid = 0; i_ls_we = 0; i_ls_addr = '0; i_ls_wdata = '0;
    i_mem_rdata_valid = 0; i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rstn = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1;
  endtask

  task automatic run_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat,
                         input logic [DW-1:0] mdata, input int cancel_at, input bit ls_pend);
    ren_cnt = 0; ren_cyc = -1; wen_cnt = 0; wen_cyc = -1; wdv_cnt = 0; ls_acc_cyc = -1;
    if_rsp_cnt = 0; if_rsp_cyc = -1; ls_rsp_cnt = 0; ls_rsp_cyc = -1;
    if (port) begin
      i_ls_valid = 1; i_ls_we = we; i_ls_addr = addr; i_ls_wdata = wdata;
    end else begin
      i_if_valid = 1; i_if_addr = addr;
    end
    @(negedge i_clk);
    obs_ready       = port ? o_ls_ready : o_if_ready;
    obs_other_ready = port ? o_if_ready : o_ls_ready;
    @(posedge i_clk); #1;
    idle_inputs();
    for (int cyc = 1; cyc <= TO + 8; cyc++) begin
      i_mem_rdata_valid = (cyc == lat + 1);
      i_mem_rdata = (cyc == lat + 1) ? mdata : DW'($urandom);
      i_if_cancel = (cyc == cancel_at);
      if (ls_pend && ls_acc_cyc < 0) begin
        i_ls_valid = 1; i_ls_we = 1; i_ls_addr = PEND_ADDR; i_ls_wdata = PEND_DATA;
      end
      @(negedge i_clk);
      if (o_mem_ren) begin ren_cnt++; ren_cyc = cyc; ren_addr = o_mem_raddr; end
      if (o_mem_wen) begin wen_cnt++; wen_cyc = cyc; wen_addr = o_mem_waddr; wen_data = o_mem_wdata; end
      if (o_mem_wdata_valid) wdv_cnt++;
      if (o_if_rsp_valid) begin
        if_rsp_cnt++;
        if (if_rsp_cnt == 1) begin if_rsp_cyc = cyc; if_rsp_data = o_if_rdata; if_rsp_err = o_if_err; end
      end
      if (o_ls_rsp_valid) begin
        ls_rsp_cnt++;
        if (ls_rsp_cnt == 1) begin ls_rsp_cyc = cyc; ls_rsp_data = o_ls_rdata; ls_rsp_err = o_ls_err; end
      end
      if (ls_pend && ls_acc_cyc < 0 && o_ls_ready) ls_acc_cyc = cyc;
      @(posedge i_clk); #1;
      idle_inputs();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rstn = 0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++; $display("[TB] FAIL reset_outputs: got %0h expected 0", all_outs);
    end
    @(posedge i_clk); #1 i_rstn = 1;
  endtask

  task automatic test_fetch_read();
    run_txn(0, 0, '0, '0, 2, 32'h114, -1, 0);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_other_ready !== 1'b0) begin
      n_errors++; $display("[TB] FAIL fetch_ready: got %b/%b expected 1/0", obs_ready, obs_other_ready);
    end
    n_checks++;
    if (ren_cnt != 1 || ren_cyc != 1 || ren_addr !== '0) begin
      n_errors++; $display("[TB] FAIL fetch_ren: got cnt %0d cyc %0d addr %0h expected 1 1 0", ren_cnt, ren_cyc, ren_addr);
    end
    n_checks++;
    if (if_rsp_cnt != 1 || if_rsp_cyc != model_rsp_cyc(2)) begin
      n_errors++; $display("[TB] FAIL fetch_rsp_cycle: got cnt %0d cyc %0d expected 1 %0d", if_rsp_cnt, if_rsp_cyc, model_rsp_cyc(2));
    end
    n_checks++;
    if (if_rsp_data !== 32'h114 || if_rsp_err !== 1'b0 || ls_rsp_cnt != 0) begin
      n_errors++; $display("[TB] FAIL fetch_rsp_data: got %0h err %b ls %0d expected 114 0 0", if_rsp_data, if_rsp_err, ls_rsp_cnt);
    end
  endtask

  task automatic test_write();
    run_txn(1, 1, 32'h5, 32'hAAAA_AAAD, 100, '0, -1, 0);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_other_ready !== 1'b0) begin
      n_errors++; $display("[TB] FAIL write_ready: got %b/%b expected 1/0", obs_ready, obs_other_ready);
    end
    n_checks++;
    if (wen_cnt != 1 || wdv_cnt != 1 || wen_cyc != 1 || ren_cnt != 0) begin
      n_errors++; $display("[TB] FAIL write_wen: got wen %0d wdv %0d cyc %0d ren %0d expected 1 1 1 0", wen_cnt, wdv_cnt, wen_cyc, ren_cnt);
    end
    n_checks++;
    if (wen_addr !== 32'h5 || wen_data !== 32'hAAAA_AAAD) begin
      n_errors++; $display("[TB] FAIL write_payload: got %0h/%0h expected 5/aaaaaaad", wen_addr, wen_data);
    end
    n_checks++;
    if (ls_rsp_cnt != 1 || ls_rsp_cyc != 2 || ls_rsp_err !== 1'b0 || ls_rsp_data !== '0) begin
      n_errors++; $display("[TB] FAIL write_ack: got cnt %0d cyc %0d err %b data %0h expected 1 2 0 0", ls_rsp_cnt, ls_rsp_cyc, ls_rsp_err, ls_rsp_data);
    end
  endtask

  task automatic test_timeout_back_to_back();
    run_txn(0, 0, 32'h80, '0, 100, '0, -1, 1);
    n_checks++;
    if (if_rsp_cnt != 1 || if_rsp_cyc != TO + 2 || if_rsp_err !== 1'b1 || if_rsp_data !== '0) begin
      n_errors++; $display("[TB] FAIL timeout_rsp: got cnt %0d cyc %0d err %b data %0h expected 1 %0d 1 0", if_rsp_cnt, if_rsp_cyc, if_rsp_err, if_rsp_data, TO + 2);
    end
    n_checks++;
    if (ls_acc_cyc != TO + 2) begin
      n_errors++; $display("[TB] FAIL timeout_next_accept: got %0d expected %0d", ls_acc_cyc, TO + 2);
    end
    n_checks++;
    if (wen_cyc != TO + 3 || wen_addr !== PEND_ADDR || ls_rsp_cyc != TO + 4) begin
      n_errors++; $display("[TB] FAIL timeout_next_write: got wen %0d addr %0h ack %0d expected %0d %0h %0d", wen_cyc, wen_addr, ls_rsp_cyc, TO + 3, PEND_ADDR, TO + 4);
    end
  endtask

  task automatic test_timeout_boundary();
    run_txn(1, 0, 32'h10, '0, TO, 32'hBEEF_0010, -1, 0);
    n_checks++;
    if (ls_rsp_cnt != 1 || ls_rsp_cyc != TO + 2 || ls_rsp_err !== 1'b0 || ls_rsp_data !== 32'hBEEF_0010) begin
      n_errors++; $display("[TB] FAIL boundary_last_wait: got cnt %0d cyc %0d err %b data %0h expected 1 %0d 0 beef0010", ls_rsp_cnt, ls_rsp_cyc, ls_rsp_err, ls_rsp_data, TO + 2);
    end
    run_txn(1, 0, 32'h11, '0, TO + 1, 32'hBEEF_0011, -1, 0);
    n_checks++;
    if (ls_rsp_cnt != 1 || ls_rsp_cyc != TO + 2 || ls_rsp_err !== 1'b1 || ls_rsp_data !== '0) begin
      n_errors++; $display("[TB] FAIL boundary_late_data: got cnt %0d cyc %0d err %b data %0h expected 1 %0d 1 0", ls_rsp_cnt, ls_rsp_cyc, ls_rsp_err, ls_rsp_data, TO + 2);
    end
  endtask

  task automatic test_cancel();
    run_txn(0, 0, 32'h200, '0, 5, 32'h1234_5678, 3, 1);
    n_checks++;
    if (if_rsp_cnt != 0) begin
      n_errors++; $display("[TB] FAIL cancel_suppress: got %0d fetch responses expected 0", if_rsp_cnt);
    end
    n_checks++;
    if (ls_acc_cyc != model_rsp_cyc(5) || ls_rsp_cyc != model_rsp_cyc(5) + 2 || ls_rsp_err !== 1'b0) begin
      n_errors++; $display("[TB] FAIL cancel_then_ls: got acc %0d ack %0d err %b expected %0d %0d 0", ls_acc_cyc, ls_rsp_cyc, ls_rsp_err, model_rsp_cyc(5), model_rsp_cyc(5) + 2);
    end
    run_txn(0, 0, 32'h204, '0, 2, 32'h0BAD_CAFE, model_rsp_cyc(2), 0);
    n_checks++;
    if (if_rsp_cnt != 1 || if_rsp_cyc != model_rsp_cyc(2) || if_rsp_data !== 32'h0BAD_CAFE) begin
      n_errors++; $display("[TB] FAIL cancel_in_idle: got cnt %0d cyc %0d data %0h expected 1 %0d badcafe", if_rsp_cnt, if_rsp_cyc, if_rsp_data, model_rsp_cyc(2));
    end
  endtask

  task automatic test_round_robin();
    bit last, exp_port;
    int ngrant;
    do_reset();
    i_if_valid = 1; i_if_addr = 32'h300;
    i_ls_valid = 1; i_ls_we = 1; i_ls_addr = 32'h304; i_ls_wdata = 32'h5555_0000;
    i_mem_rdata_valid = 1; i_mem_rdata = 32'h7777;
    last = 1'b1;
    ngrant = 0;
    for (int c = 0; c < 60 && ngrant < 4; c++) begin
      @(negedge i_clk);
      if (o_if_ready || o_ls_ready) begin
        exp_port = ~last;
        n_checks++;
        if (o_if_ready === o_ls_ready || o_ls_ready !== exp_port) begin
          n_errors++; $display("[TB] FAIL rr_grant%0d: got if %b ls %b expected port %0d", ngrant, o_if_ready, o_ls_ready, exp_port);
        end
        last = exp_port;
        ngrant++;
      end
      @(posedge i_clk); #1;
    end
    n_checks++;
    if (ngrant != 4) begin
      n_errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 4", ngrant);
    end
    i_if_valid = 0; i_ls_valid = 0;
    repeat (4) @(posedge i_clk);
    #1 idle_inputs();
  endtask

  task automatic test_random();
    bit port, we, tmo;
    int lat, exp_cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mdata, exp_data;
    for (int it = 0; it < 12; it++) begin
      port = 1'($urandom_range(0, 1));
      we = port ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = AW'($urandom); wdata = DW'($urandom); mdata = DW'($urandom);
      lat = int'($urandom_range(0, TO + 3));
      run_txn(port, we, addr, wdata, lat, mdata, -1, 0);
      if (we) begin
        n_checks++;
        if (wen_cyc != 1 || wen_addr !== addr || wen_data !== wdata || ls_rsp_cyc != 2 || ls_rsp_err !== 1'b0 || ren_cnt != 0) begin
          n_errors++; $display("[TB] FAIL rand%0d_write: got wen %0d %0h %0h ack %0d err %b expected 1 %0h %0h 2 0", it, wen_cyc, wen_addr, wen_data, ls_rsp_cyc, ls_rsp_err, addr, wdata);
        end
      end else begin
        tmo = model_timeout(lat);
        exp_cyc = model_rsp_cyc(lat);
        exp_data = tmo ? '0 : mdata;
        n_checks++;
        if (ren_cnt != 1 || ren_addr !== addr || wen_cnt != 0) begin
          n_errors++; $display("[TB] FAIL rand%0d_ren: got cnt %0d addr %0h wen %0d expected 1 %0h 0", it, ren_cnt, ren_addr, wen_cnt, addr);
        end
        n_checks++;
        if (port == 1'b0 && (if_rsp_cnt != 1 || ls_rsp_cnt != 0 || if_rsp_cyc != exp_cyc || if_rsp_data !== exp_data || if_rsp_err !== tmo)) begin
          n_errors++; $display("[TB] FAIL rand%0d_if_rsp: got cnt %0d/%0d cyc %0d data %0h err %b expected 1/0 %0d %0h %b", it, if_rsp_cnt, ls_rsp_cnt, if_rsp_cyc, if_rsp_data, if_rsp_err, exp_cyc, exp_data, tmo);
        end else if (port == 1'b1 && (ls_rsp_cnt != 1 || if_rsp_cnt != 0 || ls_rsp_cyc != exp_cyc || ls_rsp_data !== exp_data || ls_rsp_err !== tmo)) begin
          n_errors++; $display("[TB] FAIL rand%0d_ls_rsp: got cnt %0d/%0d cyc %0d data %0h err %b expected 1/0 %0d %0h %b", it, ls_rsp_cnt, if_rsp_cnt, ls_rsp_cyc, ls_rsp_data, ls_rsp_err, exp_cyc, exp_data, tmo);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    i_if_valid = 1; i_if_addr = 32'h400;
    @(posedge i_clk); #1 idle_inputs();
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 0;
    #2;
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++; $display("[TB] FAIL reset_mid_outputs: got %0h expected 0", all_outs);
    end
    @(posedge i_clk); #1;
    i_rstn = 1; i_mem_rdata_valid = 1; i_mem_rdata = 32'h5A5A_5A5A;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (all_outs !== '0) bad++;
      @(posedge i_clk); #1 i_mem_rdata_valid = 0;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("[TB] FAIL reset_late_rdata: got %0d non-zero output cycles expected 0", bad);
    end
    i_if_valid = 1; i_ls_valid = 1; i_ls_we = 0;
    @(negedge i_clk);
    n_checks++;
    if (o_if_ready !== 1'b1 || o_ls_ready !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_idle_grant: got if %b ls %b expected 1 0", o_if_ready, o_ls_ready);
    end
    @(posedge i_clk); #1;
    do_reset();
  endtask

  initial begin
    idle_inputs();
    $display("[TB] starting cg_mem_arbiter bench, TIMEOUT=%0d", TO);
    test_reset();
    test_fetch_read();
    test_write();
    test_timeout_back_to_back();
    test_timeout_boundary();
    test_cancel();
    test_round_robin();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cg_mem_arbiter.md
CG_MEM_ARBITER -- requirements
Module: cg_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data word width; ADDR_WIDTH, 32, word address width; TIMEOUT, 16, maximum RD_WAIT cycles (range 2..255).
REQ-002 Clock and reset SHALL be: i_clk  in  1  single clock, all logic on rising edge; i_rstn  in  1  asynchronous active-low reset.
REQ-003 Fetch port (port 0, read-only) SHALL be: i_if_valid in 1 request; i_if_addr in ADDR_WIDTH address; o_if_ready out 1 accept; o_if_rsp_valid out 1 response; o_if_rdata out DATA_WIDTH data; o_if_err out 1 timeout; i_if_cancel in 1 drop outstanding fetch.
REQ-004 Data port (port 1) SHALL be: i_ls_valid in 1; i_ls_we in 1 write; i_ls_addr in ADDR_WIDTH; i_ls_wdata in DATA_WIDTH; o_ls_ready out 1; o_ls_rsp_valid out 1; o_ls_rdata out DATA_WIDTH; o_ls_err out 1.
REQ-005 Memory side SHALL be: o_mem_ren out 1; o_mem_raddr out ADDR_WIDTH; i_mem_rdata_valid in 1; i_mem_rdata in DATA_WIDTH; o_mem_wen out 1; o_mem_wdata_valid out 1; o_mem_waddr out ADDR_WIDTH; o_mem_wdata out DATA_WIDTH.

Function
REQ-006 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
REQ-007 Acceptance SHALL occur only in IDLE: the granted port sees o_*_ready=1 combinationally in that cycle; the other port sees ready=0.
REQ-008 Single requester valid SHALL be granted; both valid SHALL grant the port not granted last (round-robin, 1-bit last_grant, updated on every acceptance).
REQ-009 On acceptance the address/wdata/owner SHALL be registered; read -> RD_ISSUE, write -> WR_ISSUE.
REQ-010 RD_ISSUE: o_mem_ren=1 and o_mem_raddr=latched address for exactly one cycle; next RD_WAIT with wait counter cleared to 0.
REQ-011 WR_ISSUE: o_mem_wen=1, o_mem_wdata_valid=1, latched waddr/wdata for exactly one cycle; next IDLE with a write ack (rsp_valid=1, err=0, rdata=0) to the data port.
REQ-012 RD_WAIT: i_mem_rdata_valid=1 -> owner rsp_valid=1, rdata=i_mem_rdata, err=0 in the next cycle; FSM -> IDLE.
REQ-013 RD_WAIT: counter increments per cycle without rdata_valid; reaching TIMEOUT -> owner rsp_valid=1, err=1, rdata=0; FSM -> IDLE.
REQ-014 rdata_valid and timeout in the same cycle SHALL resolve as data (err=0).
REQ-015 All rsp_valid SHALL be registered one-cycle pulses, asserted in the first IDLE cycle; a new acceptance SHALL be allowed in that same cycle.
REQ-016 i_if_cancel=1 while a fetch is owned (RD_ISSUE/RD_WAIT) SHALL set a sticky drop flag: the FSM still completes the transaction, but o_if_rsp_valid is suppressed; flag clears in IDLE. Cancel in IDLE SHALL have no effect.
REQ-017 i_mem_rdata_valid outside RD_WAIT SHALL be ignored.
REQ-018 Memory command outputs SHALL be registered; rdata/err outputs SHALL hold their last value while rsp_valid=0.

Reset
REQ-019 i_rstn=0 SHALL asynchronously force state IDLE, counter 0, last_grant=1 (fetch wins first contention), drop flag 0, all outputs 0.
REQ-020 Reset mid-transaction SHALL abandon it without a response; late rdata_valid after release SHALL be ignored per REQ-017.

Structure
REQ-021 Package cg_mem_arb_pkg SHALL hold the FSM state enum, port index constants (PORT_IF=0, PORT_LS=1) and counter width constant.
REQ-022 A sub-module cg_rr_arbiter2 (2-way round-robin, grant + last_grant register) SHALL implement REQ-008.

Verification
REQ-023 Fetch-only read 0x0 with memory returning 0x114 two cycles after ren -> ready in cycle N, ren in N+1, if_rsp_valid with rdata 0x114, err=0, one cycle after rdata_valid.
REQ-024 Both ports valid in the same IDLE cycle after reset, repeated -> grants alternate IF, LS, IF, LS.
REQ-025 LS write addr 0x5 data 0xAAAA_AAAD -> wen/wdata_valid one cycle at N+1 with those values, ls_rsp_valid err=0 at N+2.
REQ-026 Read with no rdata_valid, TIMEOUT=16 -> rsp_valid err=1 rdata=0 after 16 RD_WAIT cycles; then next request accepted that cycle.
REQ-027 Fetch read, i_if_cancel pulsed in RD_WAIT -> no if_rsp_valid; FSM returns to IDLE on rdata_valid; pending LS request granted next.
REQ-028 Reset asserted in RD_WAIT, rdata_valid arriving after release -> all outputs 0, no rsp_valid, state IDLE.
